// File: rtl/pkt_stream_sender.sv
// Store-and-forward packet source. Beats are written into a circular buffer
// and become visible to the reader only once their packet's last beat is
// accepted. Committed packets are replayed on a registered dout/vout/lout
// stream, gated by cts, with IPG idle cycles forced after each packet.
module pkt_stream_sender #(
  parameter int W     = 8,
  parameter int DEPTH = 64,
  parameter int IPG   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           in_data,
  input  logic                   in_val,
  input  logic                   in_last,
  output logic                   in_rdy,
  output logic [W-1:0]           dout,
  output logic                   vout,
  output logic                   lout,
  input  logic                   cts,
  output logic [$clog2(DEPTH):0] pkt_pend,
  output logic                   ovf
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int GW     = (IPG > 1) ? $clog2(IPG) : 1;
  localparam int IPG_M1 = (IPG > 0) ? IPG - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  // Each entry carries the beat plus its end-of-packet marker in the MSB.
  logic [W:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic          drop;
  logic          full;
  logic          wr_acc, wr_ovf, commit;
  logic [W:0]    rd_word;
  state_t        state, state_nx;
  logic          rd_adv, done;
  logic [GW-1:0] gap_cnt;

  // Pointers carry one extra bit so that full and empty are distinguishable.
  assign full    = (wr_ptr - rd_ptr) == PW'(DEPTH);
  assign in_rdy  = !full;
  // While dropping the remainder of an overflowed packet nothing is stored.
  assign wr_acc  = in_val && !full && !drop;
  assign wr_ovf  = in_val && full && !drop;
  assign commit  = wr_acc && in_last;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  // Buffer storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  end

  // Write side: accept, commit on last beat, rewind and drop on overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      drop   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      ovf <= wr_ovf;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (in_last) cm_ptr <= wr_ptr + PW'(1);
      end else if (wr_ovf) begin
        // Throw away the partial packet; keep discarding until its last beat.
        wr_ptr <= cm_ptr;
        drop   <= !in_last;
      end else if (in_val && drop && in_last) begin
        drop <= 1'b0;
      end
    end
  end

  // Read FSM next-state: IDLE spends one decision edge, SEND advances on cts.
  always_comb begin
    state_nx = state;
    rd_adv   = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: if (pkt_pend != '0 && cts) state_nx = S_SEND;
      S_SEND: begin
        if (cts) begin
          rd_adv = 1'b1;
          if (rd_word[W]) begin
            done     = 1'b1;
            state_nx = (IPG > 0) ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP:   if (gap_cnt == GW'(IPG_M1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM state register and gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= (state == S_GAP && state_nx == S_GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

  // Registered output stream; dout holds while idle, lout only with vout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      dout   <= '0;
      vout   <= 1'b0;
      lout   <= 1'b0;
    end else begin
      vout <= rd_adv;
      lout <= rd_adv && rd_word[W];
      if (rd_adv) begin
        dout   <= rd_word[W-1:0];
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Committed-but-unsent packet count; commit and completion cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_pend <= '0;
    end else begin
      case ({commit, done})
        2'b10:   pkt_pend <= pkt_pend + PW'(1);
        2'b01:   pkt_pend <= pkt_pend - PW'(1);
        default: pkt_pend <= pkt_pend;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_stream_sender.sv
// Bench for pkt_stream_sender. Two instances share the input stimulus:
// u0 (DEPTH=16, IPG=0) and u1 (DEPTH=8, IPG=12). Every scenario starts
// from reset and checks only the instance it targets.
module tb_pkt_stream_sender;

  localparam int IPG1 = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_val = 1'b0;
  logic       in_last = 1'b0;
  logic       cts = 1'b0;

  logic       rdy0, vout0, lout0, ovf0;
  logic [7:0] dout0;
  logic [4:0] pend0;
  logic       rdy1, vout1, lout1, ovf1;
  logic [7:0] dout1;
  logic [3:0] pend1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_stream_sender #(.W(8), .DEPTH(16), .IPG(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_last(in_last),
    .in_rdy(rdy0), .dout(dout0), .vout(vout0), .lout(lout0), .cts(cts),
    .pkt_pend(pend0), .ovf(ovf0));

  pkt_stream_sender #(.W(8), .DEPTH(8), .IPG(IPG1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_last(in_last),
    .in_rdy(rdy1), .dout(dout1), .vout(vout1), .lout(lout1), .cts(cts),
    .pkt_pend(pend1), .ovf(ovf1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_val = 1'b0; in_last = 1'b0; in_data = '0; cts = 1'b0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_val = 1'b0; in_last = 1'b0; cts = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #2;  // no clock edge in between: reset must act asynchronously
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL reset_vout0 got %b exp 0", vout0); end
    checks++; if (lout0 !== 1'b0) begin errors++; $display("FAIL reset_lout0 got %b exp 0", lout0); end
    checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf0 got %b exp 0", ovf0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_rdy0 got %b exp 1", rdy0); end
    checks++; if (pend0 !== 5'd0) begin errors++; $display("FAIL reset_pend0 got %0d exp 0", pend0); end
    checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_dout0 got %h exp 00", dout0); end
    checks++; if (vout1 !== 1'b0) begin errors++; $display("FAIL reset_vout1 got %b exp 0", vout1); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_rdy1 got %b exp 1", rdy1); end
    checks++; if (pend1 !== 4'd0) begin errors++; $display("FAIL reset_pend1 got %0d exp 0", pend1); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] e;
    do_reset();
    cts = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'((i + 1) * 17); in_val = 1'b1; in_last = (i == 3);
      tick();
    end
    in_val = 1'b0; in_last = 1'b0;
    checks++; if (pend0 !== 5'd1) begin errors++; $display("FAIL basic_pend_commit got %0d exp 1", pend0); end
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL basic_vout_early got %b exp 0", vout0); end
    tick();  // first edge after commit: decision only
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL basic_vout_decision got %b exp 0", vout0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      e = 8'((i + 1) * 17);
      checks++; if (vout0 !== 1'b1) begin errors++; $display("FAIL basic_vout beat%0d got %b exp 1", i, vout0); end
      checks++; if (dout0 !== e) begin errors++; $display("FAIL basic_dout beat%0d got %h exp %h", i, dout0, e); end
      checks++; if (lout0 !== (i == 3)) begin errors++; $display("FAIL basic_lout beat%0d got %b exp %b", i, lout0, (i == 3)); end
    end
    checks++; if (pend0 !== 5'd0) begin errors++; $display("FAIL basic_pend_done got %0d exp 0", pend0); end
    tick();
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL basic_vout_after got %b exp 0", vout0); end
    checks++; if (lout0 !== 1'b0) begin errors++; $display("FAIL basic_lout_after got %b exp 0", lout0); end
    checks++; if (dout0 !== 8'h44) begin errors++; $display("FAIL basic_dout_hold got %h exp 44", dout0); end
    cts = 1'b0;
  endtask

  task automatic test_cts_toggle();
    int idx;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_data = 8'((i + 1) * 17); in_val = 1'b1; in_last = (i == 3);
      tick();
    end
    in_val = 1'b0; in_last = 1'b0;
    cts = 1'b1;
    tick();
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL cts_decision got %b exp 0", vout0); end
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      cts = (k % 2 == 0);
      tick();
      checks++; if (vout0 !== cts) begin errors++; $display("FAIL cts_vout k%0d got %b exp %b", k, vout0, cts); end
      if (vout0) begin
        e = 8'((idx + 1) * 17);
        checks++; if (dout0 !== e) begin errors++; $display("FAIL cts_dout idx%0d got %h exp %h", idx, dout0, e); end
        checks++; if (lout0 !== (idx == 3)) begin errors++; $display("FAIL cts_lout idx%0d got %b exp %b", idx, lout0, (idx == 3)); end
        idx++;
      end
    end
    checks++; if (idx != 4) begin errors++; $display("FAIL cts_beat_count got %0d exp 4", idx); end
    checks++; if (pend0 !== 5'd0) begin errors++; $display("FAIL cts_pend got %0d exp 0", pend0); end
    cts = 1'b0;
  endtask

  task automatic test_gap();
    int first, second, idx;
    logic exp_v;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'h30 + i); in_val = 1'b1; in_last = (i == 2 || i == 5);
      tick();
    end
    in_val = 1'b0; in_last = 1'b0;
    checks++; if (pend1 !== 4'd2) begin errors++; $display("FAIL gap_pend got %0d exp 2", pend1); end
    // One decision edge, 3 beats, IPG gap edges, one decision edge, 3 beats.
    first  = 2;
    second = first + 3 + IPG1 + 1;
    idx    = 0;
    for (int t = 1; t <= second + 4; t++) begin
      cts = !(t >= 8 && t <= 10);  // dropping cts during the gap has no effect
      tick();
      exp_v = (t >= first && t < first + 3) || (t >= second && t < second + 3);
      checks++; if (vout1 !== exp_v) begin errors++; $display("FAIL gap_vout t%0d got %b exp %b", t, vout1, exp_v); end
      if (exp_v) begin
        e = 8'(8'h30 + idx);
        checks++; if (dout1 !== e) begin errors++; $display("FAIL gap_dout idx%0d got %h exp %h", idx, dout1, e); end
        checks++; if (lout1 !== (idx % 3 == 2)) begin errors++; $display("FAIL gap_lout idx%0d got %b exp %b", idx, lout1, (idx % 3 == 2)); end
        idx++;
      end
    end
    checks++; if (pend1 !== 4'd0) begin errors++; $display("FAIL gap_pend_end got %0d exp 0", pend1); end
    cts = 1'b0;
  endtask

  task automatic test_overflow();
    int n;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'hA0 + i); in_val = 1'b1; in_last = (i == 5);
      tick();
    end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL ovf_rdy_six got %b exp 1", rdy1); end
    checks++; if (pend1 !== 4'd1) begin errors++; $display("FAIL ovf_pend_first got %0d exp 1", pend1); end
    for (int j = 0; j < 5; j++) begin
      in_data = 8'(8'hB0 + j); in_val = 1'b1; in_last = (j == 4);
      tick();
      checks++; if (rdy1 !== (j != 1)) begin errors++; $display("FAIL ovf_rdy j%0d got %b exp %b", j, rdy1, (j != 1)); end
      checks++; if (ovf1 !== (j == 2)) begin errors++; $display("FAIL ovf_pulse j%0d got %b exp %b", j, ovf1, (j == 2)); end
    end
    in_val = 1'b0; in_last = 1'b0;
    tick();
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_after got %b exp 0", ovf1); end
    checks++; if (pend1 !== 4'd1) begin errors++; $display("FAIL ovf_pend got %0d exp 1", pend1); end
    // Drain: only the first packet may appear; then a fresh packet must pass.
    cts = 1'b1;
    n = 0;
    for (int t = 0; t < 60; t++) begin
      if (t == 10) begin in_data = 8'hC0; in_val = 1'b1; in_last = 1'b0; end
      else if (t == 11) begin in_data = 8'hC1; in_val = 1'b1; in_last = 1'b1; end
      else begin in_val = 1'b0; in_last = 1'b0; end
      tick();
      if (vout1) begin
        e = (n < 6) ? 8'(8'hA0 + n) : 8'(8'hC0 + n - 6);
        checks++;
        if (n >= 8) begin errors++; $display("FAIL ovf_extra_beat got %h exp none", dout1); end
        else if (dout1 !== e || lout1 !== (n == 5 || n == 7)) begin
          errors++; $display("FAIL ovf_drain n%0d got %h/%b exp %h/%b", n, dout1, lout1, e, (n == 5 || n == 7));
        end
        n++;
      end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL ovf_drain_count got %0d exp 8", n); end
    checks++; if (pend1 !== 4'd0) begin errors++; $display("FAIL ovf_pend_end got %0d exp 0", pend1); end
    cts = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    cts = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'((i + 1) * 17); in_val = 1'b1; in_last = (i == 3);
      tick();
    end
    in_val = 1'b0; in_last = 1'b0;
    tick(); tick(); tick();  // decision, beat 1, beat 2
    checks++; if (vout0 !== 1'b1 || dout0 !== 8'h22) begin errors++; $display("FAIL rmid_beat2 got %b/%h exp 1/22", vout0, dout0); end
    rst = 1'b0;
    #1;
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL rmid_vout got %b exp 0", vout0); end
    checks++; if (lout0 !== 1'b0) begin errors++; $display("FAIL rmid_lout got %b exp 0", lout0); end
    checks++; if (pend0 !== 5'd0) begin errors++; $display("FAIL rmid_pend got %0d exp 0", pend0); end
    tick();
    rst = 1'b1;
    tick();
    in_data = 8'h5A; in_val = 1'b1; in_last = 1'b0; tick();
    in_data = 8'hA5; in_val = 1'b1; in_last = 1'b1; tick();
    in_val = 1'b0; in_last = 1'b0;
    tick();
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL rmid_decision got %b exp 0", vout0); end
    tick();
    checks++; if (vout0 !== 1'b1 || dout0 !== 8'h5A || lout0 !== 1'b0) begin errors++; $display("FAIL rmid_new0 got %b/%h/%b exp 1/5a/0", vout0, dout0, lout0); end
    tick();
    checks++; if (vout0 !== 1'b1 || dout0 !== 8'hA5 || lout0 !== 1'b1) begin errors++; $display("FAIL rmid_new1 got %b/%h/%b exp 1/a5/1", vout0, dout0, lout0); end
    tick();
    checks++; if (vout0 !== 1'b0) begin errors++; $display("FAIL rmid_stale got %b exp 0", vout0); end
    cts = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] expq[$];
    logic [8:0] w;
    int pkts_w, beats_left, pend_m, cyc, committed, cur, out_total;
    logic offer, cts_d;
    do_reset();
    pkts_w = 0; beats_left = 0; pend_m = 0; cyc = 0; committed = 0; cur = 0; out_total = 0;
    while ((pkts_w < 40 || beats_left > 0 || expq.size() > 0) && cyc < 6000) begin
      cts = ($urandom_range(0, 3) != 0);
      if (beats_left == 0 && pkts_w < 40) begin
        beats_left = $urandom_range(1, 7);
        pkts_w++;
      end
      offer   = (beats_left > 0) && rdy0 && ($urandom_range(0, 4) != 0);
      in_val  = offer;
      in_data = 8'($urandom);
      in_last = offer && (beats_left == 1);
      cts_d   = cts;
      tick();
      cyc++;
      if (offer) begin
        expq.push_back({in_last, in_data});
        beats_left--;
        cur++;
        if (in_last) begin pend_m++; committed += cur; cur = 0; end
      end
      checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL rnd_ovf cyc%0d got %b exp 0", cyc, ovf0); end
      if (vout0) begin
        out_total++;
        checks++; if (!cts_d) begin errors++; $display("FAIL rnd_vout_no_cts cyc%0d got 1 exp 0", cyc); end
        checks++; if (out_total > committed) begin errors++; $display("FAIL rnd_uncommitted cyc%0d got %0d exp <=%0d", cyc, out_total, committed); end
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_extra cyc%0d got %h exp none", cyc, dout0);
        end else begin
          w = expq.pop_front();
          if ({lout0, dout0} !== w) begin errors++; $display("FAIL rnd_beat cyc%0d got %b/%h exp %b/%h", cyc, lout0, dout0, w[8], w[7:0]); end
        end
        if (lout0) pend_m--;
      end
      checks++; if (pend0 !== 5'(pend_m)) begin errors++; $display("FAIL rnd_pend cyc%0d got %0d exp %0d", cyc, pend0, pend_m); end
    end
    in_val = 1'b0; in_last = 1'b0; cts = 1'b0;
    checks++; if (cyc >= 6000) begin errors++; $display("FAIL rnd_timeout got %0d cycles exp <6000", cyc); end
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL rnd_leftover got %0d beats exp 0", expq.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cts_toggle();
    test_gap();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
